// File: rtl/control_unit.sv
// control_unit: multi-cycle decode/sequencing FSM for a small RV64 subset
// (ADD, SUB, ADDI, LD, SD) driving register selectors and write enables.
module control_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] immediate,
  output logic        sub,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic        R_type,
  output logic        I_type,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t state, next;

  logic [31:0] ir;
  logic        we_rf_q;
  logic        we_mem_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_add, is_sub, is_addi, is_ld, is_sd;
  logic        legal;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;
  logic [11:0] d_imm;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  assign is_add  = opc == 7'b0110011 && f3 == 3'b000
                && f7 == 7'b0000000;
  assign is_sub  = opc == 7'b0110011 && f3 == 3'b000
                && f7 == 7'b0100000;
  assign is_addi = opc == 7'b0010011 && f3 == 3'b000;
  assign is_ld   = opc == 7'b0000011 && f3 == 3'b011;
  assign is_sd   = opc == 7'b0100011 && f3 == 3'b011;
  assign legal   = is_add | is_sub | is_addi | is_ld | is_sd;

  // Field decode of the latched instruction word
  always_comb begin
    d_rs2 = 5'd0;
    d_rd  = ir[11:7];
    d_imm = 12'd0;
    if (is_add | is_sub | is_sd)
      d_rs2 = ir[24:20];
    if (is_sd)
      d_rd = 5'd0;
    unique case (1'b1)
      is_addi, is_ld: d_imm = ir[31:20];
      is_sd:          d_imm = {ir[31:25], ir[11:7]};
      default:        d_imm = 12'd0;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  // Next-state sequencing
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (instr_valid) next = DECODE;
      DECODE:  next = legal ? EXEC : ERR;
      EXEC:    next = WRITE;
      WRITE:   next = DONE;
      DONE:    next = IDLE;
      ERR:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Instruction latch, held decode outputs and retire counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      immediate <= '0;
      sub       <= 1'b0;
      R_type    <= 1'b0;
      I_type    <= 1'b0;
      we_rf_q   <= 1'b0;
      we_mem_q  <= 1'b0;
      retired   <= '0;
    end else begin
      if (state == IDLE && instr_valid)
        ir <= instr;
      if (state == DECODE && legal) begin
        rs1       <= ir[19:15];
        rs2       <= d_rs2;
        rd        <= d_rd;
        immediate <= d_imm;
        sub       <= is_sub;
        R_type    <= is_add | is_sub | is_addi;
        I_type    <= is_addi | is_ld | is_sd;
        we_rf_q   <= (is_add | is_sub | is_addi | is_ld)
                  && d_rd != 5'd0;
        we_mem_q  <= is_sd;
      end
      if (state == WRITE)
        retired <= retired + 16'd1;
    end
  end

  // Handshake, strobes and write enables from the current state
  always_comb begin
    instr_ready = state == IDLE && !RST;
    WE_RF       = state == WRITE && we_rf_q;
    WE_MEM      = state == WRITE && we_mem_q;
    done        = state == DONE;
    illegal     = state == ERR;
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven vectors with a retire/reject scoreboard
// for control_unit, plus reset-abort and counter-wrap sequences.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, WE_RF, WE_MEM, R_type, I_type;
  logic        done, illegal;
  logic [15:0] retired;

  control_unit dut (
    .CLK(CLK), .RST(RST),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .immediate(immediate), .sub(sub),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM),
    .R_type(R_type), .I_type(I_type),
    .done(done), .illegal(illegal),
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        ill;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic        sub, r_t, i_t, we_rf, we_mem;
  } vec_t;

  typedef struct {
    logic        ill;
    logic [15:0] ret;
  } sb_t;

  vec_t tbl[10];
  sb_t  sbq[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_ret;
  vec_t        last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done/illegal pulse pops one expectation
  always @(negedge CLK) begin
    if (done || illegal) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got done=%0b illegal=%0b want none",
                 done, illegal);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_kind", {30'd0, illegal, done}, {30'd0, e.ill, !e.ill});
        chk("sb_retired", {16'd0, retired}, {16'd0, e.ret});
      end
    end
  end

  task automatic chk_fields(input string nm, input vec_t v);
    chk({nm, "_rs1"}, {27'd0, rs1}, {27'd0, v.rs1});
    chk({nm, "_rs2"}, {27'd0, rs2}, {27'd0, v.rs2});
    chk({nm, "_rd"}, {27'd0, rd}, {27'd0, v.rd});
    chk({nm, "_imm"}, {20'd0, immediate}, {20'd0, v.imm});
    chk({nm, "_ctl"}, {29'd0, sub, R_type, I_type},
        {29'd0, v.sub, v.r_t, v.i_t});
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (!instr_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_ready_timeout: got 0 want 1", nm);
    end
  endtask

  // Issue one instruction; full=1 checks every cycle of its flight
  task automatic issue(input vec_t v, input bit full);
    sb_t e;
    wait_ready(v.name);
    instr       = v.instr;
    instr_valid = 1'b1;
    e.ill = v.ill;
    e.ret = v.ill ? exp_ret : exp_ret + 16'd1;
    sbq.push_back(e);
    @(negedge CLK);
    instr_valid = 1'b1;
    instr       = $urandom;
    if (full) begin
      chk({v.name, "_dec_ready"}, {31'd0, instr_ready}, 32'd0);
      chk({v.name, "_dec_we"}, {30'd0, WE_RF, WE_MEM}, 32'd0);
    end
    @(negedge CLK);
    instr_valid = 1'b0;
    if (v.ill) begin
      if (full) begin
        chk({v.name, "_err_pulse"}, {31'd0, illegal}, 32'd1);
        chk({v.name, "_err_we"}, {30'd0, WE_RF, WE_MEM}, 32'd0);
        chk_fields({v.name, "_hold"}, last);
      end
      @(negedge CLK);
      if (full) begin
        chk({v.name, "_err_end"}, {31'd0, illegal}, 32'd0);
        chk({v.name, "_err_ready"}, {31'd0, instr_ready}, 32'd1);
        chk({v.name, "_err_ret"}, {16'd0, retired}, {16'd0, exp_ret});
      end
      return;
    end
    if (full) begin
      chk_fields({v.name, "_exec"}, v);
      chk({v.name, "_exec_we"}, {30'd0, WE_RF, WE_MEM}, 32'd0);
    end
    @(negedge CLK);
    if (full) begin
      chk({v.name, "_write_we"}, {30'd0, WE_RF, WE_MEM},
          {30'd0, v.we_rf, v.we_mem});
      chk_fields({v.name, "_write"}, v);
    end
    @(negedge CLK);
    exp_ret = exp_ret + 16'd1;
    if (full) begin
      chk({v.name, "_done"}, {31'd0, done}, 32'd1);
      chk({v.name, "_done_we"}, {30'd0, WE_RF, WE_MEM}, 32'd0);
      chk({v.name, "_done_ready"}, {31'd0, instr_ready}, 32'd0);
    end
    @(negedge CLK);
    if (full) begin
      chk({v.name, "_idle_ready"}, {31'd0, instr_ready}, 32'd1);
      chk({v.name, "_idle_done"}, {31'd0, done}, 32'd0);
    end
    last = v;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"},
        {23'd0, instr_ready, sub, WE_RF, WE_MEM, R_type, I_type,
         done, illegal},
        32'd0);
    chk({nm, "_regs"}, {5'd0, rs1, rs2, rd, immediate}, 32'd0);
    chk({nm, "_retired"}, {16'd0, retired}, 32'd0);
  endtask

  initial begin
    vec_t z;
    vec_t fast;
    //        name    instr         ill rs1 rs2 rd  imm     sub r i wrf wm
    tbl[0] = '{"add",  32'h002081B3, 0, 1, 2, 3, 12'h000, 0, 1, 0, 1, 0};
    tbl[1] = '{"sub",  32'h407302B3, 0, 6, 7, 5, 12'h000, 1, 1, 0, 1, 0};
    tbl[2] = '{"addi", 32'hFFF00093, 0, 0, 0, 1, 12'hFFF, 0, 1, 1, 1, 0};
    tbl[3] = '{"sd",   32'h0020B423, 0, 1, 2, 0, 12'h008, 0, 0, 1, 0, 1};
    tbl[4] = '{"ill0", 32'h00000000, 1, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0};
    tbl[5] = '{"ld",   32'h0080B203, 0, 1, 0, 4, 12'h008, 0, 0, 1, 1, 0};
    tbl[6] = '{"mul",  32'h022081B3, 1, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0};
    tbl[7] = '{"lw",   32'h0080A203, 1, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0};
    tbl[8] = '{"addx0", 32'h00500013, 0, 0, 0, 0, 12'h005, 0, 1, 1, 0, 0};
    tbl[9] = '{"sdneg", 32'hFE20BC23, 0, 1, 2, 0, 12'hFF8, 0, 0, 1, 0, 1};

    z = '{"zero", 32'd0, 0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 0};
    last    = z;
    exp_ret = 16'd0;

    RST         = 1'b1;
    instr       = 32'd0;
    instr_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_ready", {31'd0, instr_ready}, 32'd1);

    for (int i = 0; i < 10; i++)
      issue(tbl[i], 1'b1);

    // Reset while an LD is in its write cycle
    wait_ready("rstwr");
    instr       = tbl[5].instr;
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rstwr_we", {31'd0, WE_RF}, 32'd1);
    RST         = 1'b1;
    instr_valid = 1'b1;
    instr       = tbl[0].instr;
    @(negedge CLK);
    chk_all_zero("rstwr_after");
    @(negedge CLK);
    chk_all_zero("rstwr_hold");
    RST         = 1'b0;
    instr_valid = 1'b0;
    exp_ret     = 16'd0;
    last        = z;
    @(negedge CLK);
    chk("rstwr_ready", {31'd0, instr_ready}, 32'd1);
    repeat (5) @(negedge CLK);
    chk("rstwr_nodone_ret", {16'd0, retired}, 32'd0);
    chk("rstwr_idle", {31'd0, instr_ready}, 32'd1);

    // Retire counter wrap
    fast = tbl[2];
    for (int i = 0; i < 65535; i++)
      issue(fast, 1'b0);
    chk("wrap_pre", {16'd0, retired}, 32'h0000FFFF);
    last = fast;
    issue(tbl[8], 1'b1);
    chk("wrap_post", {16'd0, retired}, 32'd0);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
